// File: rtl/crt_pkg.sv
// Purpose : shared widths, register-bank size and loader state encoding for the CRTC loader.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package crt_pkg;

  localparam int CRT_ADDR_WIDTH = 4;
  localparam int CRT_DATA_WIDTH = 8;
  localparam int CRT_NUM_REGS   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } crt_state_t;

endpackage

// File: rtl/crt_cycle_timer.sv
// Purpose : loadable down-counter; o_expire flags the last cycle of a timed phase.
// Latency : load takes effect on the next edge; o_expire is high while the count equals 1.
// Backpressure: none; the owner decides when to load.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_load         load i_load_val this edge (wins over decrement)
//   i_load_val     phase length in cycles (>=1)
//   o_expire       current cycle is the final one of the phase
module crt_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      // Parks at 0 between phases so a stale count never reports expiry.
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/crt_reg_loader.sv
// Purpose : copies ROM entries first_reg..last_reg into the CRTC register bank via addr/cs/wdata/we.
// Latency : 2 + SETUP_CYCLES + STROBE_CYCLES + 1 cycles per register; done one cycle after the last HOLD.
// Backpressure: none; start is accepted only in IDLE and is dropped (not queued) otherwise.
//
// Ports:
//   i_clk, i_rst            clock and synchronous active-high reset
//   i_start                 one-cycle request, samples i_first_reg / i_last_reg
//   o_tbl_addr / i_tbl_data ROM read port, data valid the cycle after the address changes
//   o_addr, o_cs, o_wdata,
//   o_we                    register-bank write bus to the address decoder
//   o_busy, o_done          sequence in progress / one-cycle completion pulse
module crt_reg_loader
  import crt_pkg::*;
#(
  parameter int ADDR_WIDTH    = CRT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = CRT_DATA_WIDTH,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_first_reg,
  input  logic [ADDR_WIDTH-1:0] i_last_reg,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_cs,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_we,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int TMR_W = 8;

  crt_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] r_last;
  logic                  r_fetch_last;   // second FETCH cycle: ROM data is valid now
  logic [ADDR_WIDTH-1:0] r_tbl_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_tmr_load;
  logic [TMR_W-1:0]      w_tmr_val;
  logic                  w_tmr_expire;

  // The timer is reloaded on entry to SETUP (leaving FETCH) and on entry to
  // STROBE (leaving SETUP); in every other state its count is ignored.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = TMR_W'(STROBE_CYCLES);
    if (r_state == ST_FETCH) begin
      w_tmr_load = r_fetch_last;
      w_tmr_val  = TMR_W'(SETUP_CYCLES);
    end else if (r_state == ST_SETUP) begin
      w_tmr_load = w_tmr_expire;
    end
  end

  crt_cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_tmr_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_last       <= '0;
      r_fetch_last <= 1'b0;
      r_tbl_addr   <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cs         <= 1'b0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_idx  <= i_first_reg;
            r_last <= i_last_reg;
            if (i_first_reg > i_last_reg) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_tbl_addr   <= i_first_reg;
              r_busy       <= 1'b1;
              r_fetch_last <= 1'b0;
              r_state      <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (r_fetch_last) begin
            r_wdata <= i_tbl_data;
            r_addr  <= r_idx;
            r_cs    <= 1'b1;
            r_state <= ST_SETUP;
          end else begin
            r_fetch_last <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_tmr_expire) begin
            r_we    <= 1'b1;
            r_state <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (w_tmr_expire) begin
            r_we    <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_cs <= 1'b0;
          // Compare before incrementing so last_reg = max never wraps to 0.
          if (r_idx == r_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx        <= r_idx + 1'b1;
            r_tbl_addr   <= r_idx + 1'b1;
            r_fetch_last <= 1'b0;
            r_state      <= ST_FETCH;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tbl_addr = r_tbl_addr;
  assign o_addr     = r_addr;
  assign o_cs       = r_cs;
  assign o_wdata    = r_wdata;
  assign o_we       = r_we;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_crt_reg_loader.sv
// Purpose : directed, table-driven check of crt_reg_loader with a 1-cycle-latency ROM model.
// Latency : n/a (testbench).
// Backpressure: n/a.
module tb_crt_reg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] first_reg;
  logic [3:0] last_reg;
  logic [3:0] tbl_addr;
  logic [7:0] tbl_data;
  logic [3:0] addr;
  logic       cs;
  logic [7:0] wdata;
  logic       we;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  crt_reg_loader u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_first_reg (first_reg),
    .i_last_reg  (last_reg),
    .o_tbl_addr  (tbl_addr),
    .i_tbl_data  (tbl_data),
    .o_addr      (addr),
    .o_cs        (cs),
    .o_wdata     (wdata),
    .o_we        (we),
    .o_busy      (busy),
    .o_done      (done)
  );

  // ROM: entry i holds 8'hA0 + i, registered read.
  logic [7:0] rom [16];
  initial for (int i = 0; i < 16; i++) rom[i] = 8'hA0 + 8'(i);
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void chk(input bit ok, input string name, input int act, input int exp);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Bus monitor: logs writes and checks bus protocol every cycle.
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  bit         mon_en = 1'b1;
  logic       prev_cs = 1'b0, prev_we = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [7:0] prev_wdata = '0;
  int         we_run = 0;
  int         cs_low_run = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (we && !prev_we) begin
        wr_addr_q.push_back(addr);
        wr_data_q.push_back(wdata);
      end
      if (cs && prev_cs) begin
        chk(addr == prev_addr, "addr_stable_cs", int'(addr), int'(prev_addr));
        chk(wdata == prev_wdata, "wdata_stable_cs", int'(wdata), int'(prev_wdata));
      end
      if (we) chk(cs, "we_without_cs", int'(cs), 1);
      if (we) we_run++;
      else if (prev_we) begin
        chk(we_run == 2, "strobe_width", we_run, 2);
        we_run = 0;
      end
      if (!cs && busy) cs_low_run++;
      if (cs && !prev_cs) begin
        chk(cs_low_run == 2, "cs_low_gap", cs_low_run, 2);
        cs_low_run = 0;
      end
    end
    prev_cs    = cs;
    prev_we    = we;
    prev_addr  = addr;
    prev_wdata = wdata;
  end

  // One load sequence; optionally pokes start during register 2's SETUP.
  task automatic run_seq(input logic [3:0] f, input logic [3:0] l, input bit poke,
                         output int done_cyc, output int busy_cyc);
    bit poked = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cyc = -1;
    busy_cyc = 0;
    @(negedge clk);
    start = 1'b1; first_reg = f; last_reg = l;
    @(posedge clk);
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && !poked && cs && !we && addr == 4'd2) begin
        start = 1'b1; first_reg = 4'd10; last_reg = 4'd10; poked = 1'b1;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    bit         poke;
    int         n_wr;
    int         busy_cyc;
    int         done_cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dc, bc, ea;
    bit found, seen;

    // done cycle counted in negedges after the start-sampling edge
    vecs[0] = '{4'd0,  4'd15, 1'b0, 16, 96, 97};
    vecs[1] = '{4'd4,  4'd6,  1'b0, 3,  18, 19};
    vecs[2] = '{4'd9,  4'd3,  1'b0, 0,  0,  1};
    vecs[3] = '{4'd7,  4'd7,  1'b0, 1,  6,  7};
    vecs[4] = '{4'd14, 4'd15, 1'b0, 2,  12, 13};
    vecs[5] = '{4'd0,  4'd3,  1'b1, 4,  24, 25};

    rst = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(tbl_addr == 0, "rst_tbl_addr", int'(tbl_addr), 0);
    chk(addr == 0, "rst_addr", int'(addr), 0);
    chk(wdata == 0, "rst_wdata", int'(wdata), 0);
    chk({cs, we, busy, done} == 4'b0, "rst_ctrl", int'({cs, we, busy, done}), 0);

    // start together with rst: rst wins
    start = 1'b1; first_reg = 4'd0; last_reg = 4'd3;
    @(posedge clk);
    @(negedge clk);
    chk(busy == 1'b0, "rst_beats_start", int'(busy), 0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk(busy == 1'b0, "start_not_queued", int'(busy), 0);

    for (int v = 0; v < 6; v++) begin
      run_seq(vecs[v].f, vecs[v].l, vecs[v].poke, dc, bc);
      chk(dc == vecs[v].done_cyc, "done_cycle", dc, vecs[v].done_cyc);
      chk(bc == vecs[v].busy_cyc, "busy_cycles", bc, vecs[v].busy_cyc);
      @(negedge clk);
      chk(done == 1'b0 && busy == 1'b0, "done_one_cycle", int'({done, busy}), 0);
      chk(wr_addr_q.size() == vecs[v].n_wr, "write_count", wr_addr_q.size(), vecs[v].n_wr);
      for (int i = 0; i < wr_addr_q.size(); i++) begin
        ea = int'(vecs[v].f) + i;
        chk(int'(wr_addr_q[i]) == ea, "write_addr", int'(wr_addr_q[i]), ea);
        chk(int'(wr_data_q[i]) == 160 + ea, "write_data", int'(wr_data_q[i]), 160 + ea);
      end
    end

    // start during the DONE cycle of an empty range is dropped
    wr_addr_q.delete();
    @(negedge clk);
    start = 1'b1; first_reg = 4'd9; last_reg = 4'd3;
    @(posedge clk);
    @(negedge clk);
    chk(done == 1'b1, "empty_done", int'(done), 1);
    start = 1'b1; first_reg = 4'd3; last_reg = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy || cs) seen = 1'b1;
    end
    chk(!seen && wr_addr_q.size() == 0, "start_in_done_ignored", int'(seen), 0);

    // reset during register 5's STROBE
    @(negedge clk);
    start = 1'b1; first_reg = 4'd0; last_reg = 4'd15;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (we && addr == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(found, "reach_reg5_strobe", int'(found), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk(we == 1'b0, "abort_we", int'(we), 0);
    chk(cs == 1'b0, "abort_cs", int'(cs), 0);
    chk(busy == 1'b0, "abort_busy", int'(busy), 0);
    seen = done;
    repeat (10) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(!seen, "abort_no_done", int'(seen), 0);
    we_run = 0;
    cs_low_run = 0;
    mon_en = 1'b1;

    run_seq(4'd0, 4'd1, 1'b0, dc, bc);
    chk(dc == 13, "post_rst_done_cycle", dc, 13);
    chk(bc == 12, "post_rst_busy_cycles", bc, 12);
    chk(wr_addr_q.size() == 2, "post_rst_writes", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      chk(wr_addr_q[0] == 4'd0 && wr_data_q[0] == 8'hA0, "post_rst_wr0", int'(wr_data_q[0]), 160);
      chk(wr_addr_q[1] == 4'd1 && wr_data_q[1] == 8'hA1, "post_rst_wr1", int'(wr_data_q[1]), 161);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
